// File: rtl/imm_gen_pkg.sv
// Shared types for the decode-stage immediate generator: format enum, opcodes and FIFO entry layout.
// Entry fields are sized for the widest legal XLEN; narrower builds use the low bits only.
package imm_gen_pkg;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5,
      IMM_Z    = 3'd6
   } imm_type_e;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam int XLEN_MAX = 64;

   typedef struct packed {
      logic [XLEN_MAX-1:0] imm;
      imm_type_e           itype;
      logic [XLEN_MAX-1:0] target;
      logic                illegal;
   } imm_entry_t;

   // Only branches, jumps and AUIPC produce a PC-relative target.
   function automatic logic has_target(input imm_type_e t, input logic [6:0] opcode);
      return (t == IMM_B) || (t == IMM_J) || (opcode == OPC_AUIPC);
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV immediate decoder: inst_code -> sign-extended imm, format and illegal flag.
// Define IMM_GEN_ZICSR_EN to decode the CSR immediate forms of the SYSTEM opcode.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst_code,
   output logic [XLEN-1:0] imm,
   output imm_type_e       imm_type,
   output logic            illegal
);

   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      imm      = '0;
      imm_type = IMM_NONE;
      illegal  = 1'b0;
      case (inst_code[6:0])
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
            imm      = XLEN'($signed(inst_code[31:20]));
            imm_type = IMM_I;
         end
         OPC_STORE: begin
            imm      = XLEN'($signed({inst_code[31:25], inst_code[11:7]}));
            imm_type = IMM_S;
         end
         OPC_BRANCH: begin
            imm      = XLEN'($signed({inst_code[31], inst_code[7], inst_code[30:25],
                                      inst_code[11:8], 1'b0}));
            imm_type = IMM_B;
         end
         OPC_LUI, OPC_AUIPC: begin
            imm      = XLEN'($signed({inst_code[31:12], 12'b0}));
            imm_type = IMM_U;
         end
         OPC_JAL: begin
            imm      = XLEN'($signed({inst_code[31], inst_code[19:12], inst_code[20],
                                      inst_code[30:21], 1'b0}));
            imm_type = IMM_J;
         end
`ifdef IMM_GEN_ZICSR_EN
         OPC_SYSTEM: begin
            // funct3[2] selects the uimm CSR forms; the register forms carry no immediate.
            if (inst_code[14]) begin
               imm      = XLEN'(inst_code[19:15]);
               imm_type = IMM_Z;
            end
         end
`else
         OPC_SYSTEM: illegal = 1'b1;
`endif
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/imm_gen_pipe.sv
// Buffered immediate generator: decodes on push, adds the PC-relative target and queues results
// in a BUF_DEPTH-entry FIFO. Optional CSR decode is enabled by defining IMM_GEN_ZICSR_EN.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int BUF_DEPTH = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     inst_code,
   input  logic [XLEN-1:0] in_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_type,
   output logic [XLEN-1:0] out_target,
   output logic            out_illegal
);

   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [XLEN-1:0]  dec_imm;
   imm_type_e        dec_type;
   logic             dec_illegal;
   logic [XLEN-1:0]  target;
   imm_entry_t       wr_entry;
   imm_entry_t       head;
   imm_entry_t       mem [BUF_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic             push;
   logic             pop;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .inst_code (inst_code),
      .imm       (dec_imm),
      .imm_type  (dec_type),
      .illegal   (dec_illegal)
   );

   // A full FIFO never accepts, even when the head leaves in the same cycle.
   assign in_ready  = (count < CNT_W'(BUF_DEPTH));
   assign out_valid = (count != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   assign target = has_target(dec_type, inst_code[6:0]) ? (in_pc + dec_imm) : '0;

   always_comb begin
      wr_entry                    = '0;
      wr_entry.imm[XLEN-1:0]      = dec_imm;
      wr_entry.itype              = dec_type;
      wr_entry.target[XLEN-1:0]   = target;
      wr_entry.illegal            = dec_illegal;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         // NOTE: storage is cleared on reset so the idle head drives zeros, not stale data.
         for (int i = 0; i < BUF_DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         count  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_entry;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign head        = mem[rd_ptr];
   assign out_imm     = head.imm[XLEN-1:0];
   assign out_type    = head.itype;
   assign out_target  = head.target[XLEN-1:0];
   assign out_illegal = head.illegal;

   // Upper halves of the entry are only meaningful when XLEN is 64.
   logic unused_hi;
   assign unused_hi = ^{head.imm, head.target};

endmodule
